// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline trace buffer.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trace_state_t;

   localparam int TRACE_TS_W = 32;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Contents are not cleared by reset; only the read register is.
module trace_ram #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Circular trace capture with PC-match trigger, post-trigger window and playback.
// Optional TRACE_TIMESTAMP_EN stores a free-running cycle stamp with every entry.
module pipeline_trace_buffer
   import trace_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int N_CH      = 2,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       trig_en,
   input  logic [XLEN-1:0]            trig_pc,
   input  logic                       cap_valid,
   input  logic [N_CH*XLEN-1:0]       cap_data,
   input  logic                       rd_req,
   output logic                       rd_valid,
   output logic [N_CH*XLEN-1:0]       rd_data,
   output logic                       rd_last,
   output logic                       triggered,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TRACE_TS_W-1:0]      rd_ts,
`endif
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int DW = N_CH*XLEN;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [AW:0]   POST_LIM = (AW+1)'(POST_TRIG);
`ifdef TRACE_TIMESTAMP_EN
   localparam int RW = DW + TRACE_TS_W;
`else
   localparam int RW = DW;
`endif

   trace_state_t  state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
   logic [CW-1:0] count_q, count_d, rem_q, rem_d;
   logic          trig_q, trig_d;
   logic          trigger_hit, wr_en, rd_fire;
   logic [RW-1:0] wdata, rdata;

   assign trigger_hit = cap_valid & trig_en & (cap_data[XLEN-1:0] == trig_pc);
   assign wr_en   = ~arm & cap_valid & ((state_q == ARMED) | (state_q == POST));
   assign rd_fire = ~arm & rd_req & (state_q == DONE) & (rem_q != '0);

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      post_d   = post_q;
      rd_ptr_d = rd_ptr_q;
      rem_d    = rem_q;
      trig_d   = trig_q;
      if (arm) begin
         state_d  = ARMED;
         wr_ptr_d = '0;
         count_d  = '0;
         post_d   = '0;
         rd_ptr_d = '0;
         rem_d    = '0;
         trig_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED, POST: begin
               if (cap_valid) begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = (count_q == FULL) ? count_q : count_q + 1'b1;
                  if (state_q == ARMED) begin
                     if (trigger_hit) begin
                        trig_d  = 1'b1;
                        state_d = (POST_TRIG == 0) ? DONE : POST;
                     end
                  end else begin
                     post_d = post_q + 1'b1;
                     if (({1'b0, post_q} + 1'b1) == POST_LIM) state_d = DONE;
                  end
               end
               // Playback starts at the oldest entry of the frozen window.
               if (state_d == DONE) begin
                  rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                  rem_d    = count_d;
               end
            end
            DONE: begin
               if (rd_fire) begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  rem_d    = rem_q - 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         post_q   <= '0;
         rd_ptr_q <= '0;
         rem_q    <= '0;
         trig_q   <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         post_q   <= post_d;
         rd_ptr_q <= rd_ptr_d;
         rem_q    <= rem_d;
         trig_q   <= trig_d;
         rd_valid <= rd_fire;
         rd_last  <= rd_fire & (rem_q == CW'(1));
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TRACE_TS_W-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + 1'b1;
   end

   assign wdata = {ts_q, cap_data};
   assign rd_ts = rdata[RW-1 -: TRACE_TS_W];
`else
   assign wdata = cap_data;
`endif

   trace_ram #(.WIDTH(RW), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (wdata),
      .re    (rd_fire),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   assign rd_data   = rdata[DW-1:0];
   assign triggered = trig_q;
   assign state     = state_q;
   assign count     = count_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: POST_TRIG=8 and POST_TRIG=0 instances share stimulus
// and are checked every cycle against a sample-history reference model.
module tb_pipeline_trace_buffer;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, arm, trig_en, cv, rd_req;
   logic [31:0] trig_pc, pc, alu;
   logic [1:0]  rdv, rdl, trg;
   logic [63:0] rdd [2];
   logic [1:0]  st  [2];
   logic [4:0]  cnt [2];
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts  [2];
   logic [31:0] prev_ts;
`endif

   always #5 clk = ~clk;

   pipeline_trace_buffer #(.XLEN(XLEN), .N_CH(2), .DEPTH(DEPTH), .POST_TRIG(8)) dut_a (
      .clk(clk), .reset(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .cap_valid(cv), .cap_data({alu, pc}), .rd_req(rd_req), .rd_valid(rdv[0]),
      .rd_data(rdd[0]), .rd_last(rdl[0]), .triggered(trg[0]),
`ifdef TRACE_TIMESTAMP_EN
      .rd_ts(ts[0]),
`endif
      .state(st[0]), .count(cnt[0]));

   pipeline_trace_buffer #(.XLEN(XLEN), .N_CH(2), .DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
      .clk(clk), .reset(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .cap_valid(cv), .cap_data({alu, pc}), .rd_req(rd_req), .rd_valid(rdv[1]),
      .rd_data(rdd[1]), .rd_last(rdl[1]), .triggered(trg[1]),
`ifdef TRACE_TIMESTAMP_EN
      .rd_ts(ts[1]),
`endif
      .state(st[1]), .count(cnt[1]));

   // Reference model: all samples seen since arm, plus per-instance progress.
   logic [63:0] since_arm [$];
   int          m_state [2], m_n [2], m_post [2], m_rd [2];
   bit          m_trig [2], exp_valid [2], exp_last [2];
   logic [63:0] exp_data [2];
   int          n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input int inst, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s[%0d] got=%0h exp=%0h at %0t", tag, inst, got, exp, $time);
   endtask

   function automatic int avail(input int i);
      return (m_n[i] < DEPTH) ? m_n[i] : DEPTH;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int pt;
         pt = (i == 0) ? 8 : 0;
         exp_valid[i] = 1'b0;
         exp_last[i]  = 1'b0;
         if (rst) begin
            m_state[i] = 0; m_n[i] = 0; m_trig[i] = 0; m_rd[i] = 0; exp_data[i] = '0;
         end else if (arm) begin
            m_state[i] = 1; m_n[i] = 0; m_post[i] = 0; m_trig[i] = 0; m_rd[i] = 0;
         end else if (m_state[i] == 1 || m_state[i] == 2) begin
            if (cv) begin
               m_n[i]++;
               if (m_state[i] == 1) begin
                  if (trig_en && pc == trig_pc) begin
                     m_trig[i] = 1;
                     m_post[i] = 0;
                     m_state[i] = (pt == 0) ? 3 : 2;
                  end
               end else begin
                  m_post[i]++;
                  if (m_post[i] == pt) m_state[i] = 3;
               end
            end
         end else if (m_state[i] == 3) begin
            if (rd_req && m_rd[i] < avail(i)) begin
               exp_valid[i] = 1'b1;
               exp_data[i]  = since_arm[m_n[i] - avail(i) + m_rd[i]];
               exp_last[i]  = (m_rd[i] == avail(i) - 1);
               m_rd[i]++;
            end
         end
      end
      if (rst || arm) since_arm.delete();
      else if (cv) since_arm.push_back({alu, pc});
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check("state", i, 64'(st[i]), 64'(m_state[i]));
         check("count", i, 64'(cnt[i]), 64'(avail(i)));
         check("triggered", i, 64'(trg[i]), 64'(m_trig[i]));
         check("rd_valid", i, 64'(rdv[i]), 64'(exp_valid[i]));
         if (exp_valid[i]) begin
            check("rd_data", i, rdd[i], exp_data[i]);
            check("rd_last", i, 64'(rdl[i]), 64'(exp_last[i]));
         end
      end
`ifdef TRACE_TIMESTAMP_EN
      if (exp_valid[0]) begin
         if (m_rd[0] > 1) check("rd_ts_incr", 0, 64'(ts[0] > prev_ts), 64'd1);
         prev_ts = ts[0];
      end
`endif
   endtask

   task automatic cycle(input bit a, input bit v, input logic [31:0] p,
                        input logic [31:0] al, input bit r);
      arm = a; cv = v; pc = p; alu = al; rd_req = r;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_ramp(input logic [31:0] base, input int n_samp, input int n_rd);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < n_samp; i++) cycle(0, 1, base + 32'(4*i), 32'(i), 0);
      for (int k = 0; k < n_rd; k++) cycle(0, 0, 0, 0, 1);
   endtask

   initial begin
      rst = 1; arm = 0; cv = 0; rd_req = 0; pc = 0; alu = 0; trig_en = 1; trig_pc = 0;
      @(negedge clk);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      rst = 0;
      for (int i = 0; i < 2; i++) check("rd_data_reset", i, rdd[i], 64'd0);

      // Samples and reads without arm are ignored.
      for (int i = 0; i < 10; i++) cycle(0, 1, 32'(4*i), 32'(i), 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

      trig_pc = 32'h140;
      run_ramp(32'h100, 30, 17);

      // DONE with arm and rd_req together: read dropped.
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);

      trig_pc = 32'h200;
      run_ramp(32'h200, 12, 11);

      trig_pc = 32'h80;
      run_ramp(32'h60, 10, 18);

      // Reset while three post-trigger samples have been taken, then rerun.
      trig_pc = 32'h140;
      run_ramp(32'h100, 20, 0);
      rst = 1;
      cycle(0, 1, 32'h200, 0, 1);
      rst = 0;
      cycle(0, 0, 0, 0, 1);
      run_ramp(32'h100, 30, 17);

      // Randomized traffic with gaps, re-arms and occasional resets.
      trig_pc = 32'h40;
      for (int n = 0; n < 600; n++) begin
         rst = (($urandom_range(0, 149)) == 0);
         trig_en = ($urandom_range(0, 7) != 0);
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
               32'($urandom_range(0, 31) * 4), $urandom, $urandom_range(0, 1) == 1);
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
